nx_host_ctrl_initiator: RTL

- Host-side initiator for the Nexus control message stream. It drives the control inbound stream and consumes the control outbound response stream.
- Accepts one command at a time from host logic, sends it as a valid/ready message, and optionally waits for the matching response under a timeout.
- Returns a completion record (response data or timeout) to the host.
- Used in FPGA host shells and testbench harnesses in front of the accelerator top-level.

---
 rtl/nx_host_ctrl_initiator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/nx_host_ctrl_initiator.sv
// Host-side initiator for the Nexus control stream: sends one command at a time,
// optionally waits for its response under a timeout, and returns a completion record.
//
// state    | meaning
// IDLE     | ready for a host command
// SEND     | message presented on control inbound, waiting for ctrl_ready_i
// CLOSE    | message sent, no response expected; completion is built here
// WAIT_RSP | waiting for the response while the timeout timer runs
// DONE     | completion presented to the host, waiting for res_ready_i
module nx_host_ctrl_initiator #(
  parameter int MSG_WIDTH      = 32,
  parameter int RSP_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MSG_WIDTH-1:0] req_data_i,
  input  logic                 req_expect_rsp_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [MSG_WIDTH-1:0] ctrl_data_o,
  output logic                 ctrl_valid_o,
  input  logic                 ctrl_ready_i,
  input  logic [RSP_WIDTH-1:0] rsp_data_i,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  output logic [RSP_WIDTH-1:0] res_data_o,
  output logic                 res_timeout_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] unsolicited_o
);

  localparam int TMR_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_WIDTH-1:0] TMR_LOAD = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND     = 3'd1;
  localparam logic [2:0] CLOSE    = 3'd2;
  localparam logic [2:0] WAIT_RSP = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic                 expect_rsp;
  logic [TMR_WIDTH-1:0] tmr;
  logic                 req_fire;
  logic                 ctrl_fire;
  logic                 rsp_fire;
  logic                 res_fire;
  logic                 tmr_tc;

  assign req_fire  = req_valid_i & req_ready_o;
  assign ctrl_fire = ctrl_valid_o & ctrl_ready_i;
  assign rsp_fire  = rsp_valid_i & rsp_ready_o;
  assign res_fire  = res_valid_o & res_ready_i;
  assign tmr_tc    = (tmr == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_fire) state_nxt = SEND;
      SEND:     if (ctrl_fire) state_nxt = expect_rsp ? WAIT_RSP : CLOSE;
      CLOSE:    state_nxt = DONE;
      WAIT_RSP: if (rsp_fire || tmr_tc) state_nxt = DONE;
      DONE:     if (res_fire) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      req_ready_o <= 1'b0;
      rsp_ready_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_ready_o <= (state_nxt == IDLE);
      rsp_ready_o <= (state_nxt != DONE);
      busy_o      <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_data_o  <= '0;
      ctrl_valid_o <= 1'b0;
      expect_rsp   <= 1'b0;
    end else if (req_fire) begin
      ctrl_data_o  <= req_data_i;
      ctrl_valid_o <= 1'b1;
      expect_rsp   <= req_expect_rsp_i;
    end else if (ctrl_fire) begin
      ctrl_valid_o <= 1'b0;
    end
  end

  // Timeout down-counter: loaded when the message leaves, terminal count at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr <= '0;
    end else if (ctrl_fire) begin
      tmr <= TMR_LOAD;
    end else if (state == WAIT_RSP && !tmr_tc) begin
      tmr <= tmr - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_data_o    <= '0;
      res_timeout_o <= 1'b0;
      res_valid_o   <= 1'b0;
    end else begin
      case (state)
        CLOSE: begin
          res_data_o    <= '0;
          res_timeout_o <= 1'b0;
          res_valid_o   <= 1'b1;
        end
        WAIT_RSP: begin
          if (rsp_fire) begin
            res_data_o    <= rsp_data_i;
            res_timeout_o <= 1'b0;
            res_valid_o   <= 1'b1;
          end else if (tmr_tc) begin
            res_data_o    <= '0;
            res_timeout_o <= 1'b1;
            res_valid_o   <= 1'b1;
          end
        end
        DONE: if (res_fire) res_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

  // Responses accepted outside WAIT_RSP have no owner and are only counted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unsolicited_o <= '0;
    end else if (rsp_fire && state != WAIT_RSP && unsolicited_o != '1) begin
      unsolicited_o <= unsolicited_o + 1'b1;
    end
  end

endmodule
